// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: FSM encoding, status word
// bit positions, frame geometry and the decoder address of the TX register.
// Optional feature macro: UART_TX_PARITY_EN (adds an even parity state).
package uart_pkg;

   localparam int          UART_DATA_BITS     = 8;
   localparam int          STATUS_BUSY_BIT    = 0;
   localparam int          STATUS_DONE_BIT    = 1;
   localparam int          STATUS_OVERRUN_BIT = 2;
   localparam logic [31:0] UART_TX_ADDR       = 32'h1001_0030;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator shared by the UART transmitter (and the future receiver).
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit time.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - hold the counter at 0 (used while the line is idle)
//   tick  - high during the final cycle of a bit time
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_reg;

   assign tick = (cnt_reg == LAST);

   // Explicit wrap keeps non-power-of-two divisors exact.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_reg <= '0;
      end else if (tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped UART transmitter. A one-cycle write strobe latches the low
// byte of write_data and sends it as an 8N1 frame (8E1 when UART_TX_PARITY_EN
// is defined). Writes arriving while a frame is in flight are dropped and
// flagged in a sticky overrun bit.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   write_en   - one-cycle write strobe from the address decoder
//   write_data - store data; only [7:0] is transmitted
//   tx         - serial line, idle high
//   busy       - frame in progress
//   status     - {29'b0, overrun, done, busy}
module uart_tx_responder
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  tx,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] status
);

   localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

   tx_state_t                 state_reg, state_next;
   logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
   logic [2:0]                idx_reg, idx_next;
   logic                      done_reg, done_next;
   logic                      overrun_reg, overrun_next;
   logic                      tx_reg, tx_next;
   logic                      busy_reg, busy_next;
   logic                      bit_tick;
   logic                      baud_clear;
   logic                      unused_data;

`ifdef UART_TX_PARITY_EN
   logic parity_reg, parity_next;
`endif

   // Upper store bits carry no meaning for this register.
   assign unused_data = ^write_data[DATA_WIDTH-1:UART_DATA_BITS];

   // Counter held at zero while idle so the start bit gets a full bit time
   // beginning on the cycle after the write is accepted.
   assign baud_clear = (state_reg == ST_IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(baud_clear),
      .tick (bit_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      idx_next     = idx_reg;
      done_next    = done_reg;
      overrun_next = overrun_reg;
`ifdef UART_TX_PARITY_EN
      parity_next  = parity_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (write_en) begin
               shift_next = write_data[UART_DATA_BITS-1:0];
               idx_next   = '0;
               done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_next = ^write_data[UART_DATA_BITS-1:0];
`endif
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) state_next = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick) begin
               shift_next = shift_reg >> 1;
               if (idx_reg == LAST_IDX) begin
                  idx_next = '0;
`ifdef UART_TX_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) state_next = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_tick) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Any strobe outside IDLE (including the last stop-bit cycle) is lost.
      if (write_en && (state_reg != ST_IDLE)) overrun_next = 1'b1;

      // Line level is derived from the next state so tx stays a register
      // output with no combinational path from write_en.
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_next = parity_next;
`endif
         default:   tx_next = 1'b1;
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg   <= '0;
         idx_reg     <= '0;
         done_reg    <= 1'b0;
         overrun_reg <= 1'b0;
         tx_reg      <= 1'b1;
         busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= 1'b0;
`endif
      end else begin
         shift_reg   <= shift_next;
         idx_reg     <= idx_next;
         done_reg    <= done_next;
         overrun_reg <= overrun_next;
         tx_reg      <= tx_next;
         busy_reg    <= busy_next;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= parity_next;
`endif
      end
   end

   always_comb begin
      status                     = '0;
      status[STATUS_BUSY_BIT]    = busy_reg;
      status[STATUS_DONE_BIT]    = done_reg;
      status[STATUS_OVERRUN_BIT] = overrun_reg;
   end

   assign tx   = tx_reg;
   assign busy = busy_reg;

endmodule
